mips_harvard_core: RTL and testbench

- Single-cycle, 32-bit MIPS-I subset CPU with separate instruction and data buses (Harvard).
- Executes one instruction per enabled clock edge and honours the branch delay slot.
- Stops execution (`active`=0) when it jumps to address 0.
- Sits between an external combinational-read instruction ROM and a data RAM; exposes `$v0` for debug and verification.

---
 rtl/mips_harvard_core.sv | 155 +++++++++++++++
 tb/tb_mips_harvard_core.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mips_harvard_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_harvard_core: single-cycle MIPS-I subset CPU, Harvard buses,          |
// | branch delay slot, halts on jump to address 0.                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mips_harvard_core #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  localparam logic [5:0] c_OP_SPECIAL = 6'h00, c_OP_J = 6'h02, c_OP_JAL = 6'h03,
                         c_OP_BEQ = 6'h04, c_OP_BNE = 6'h05, c_OP_BLEZ = 6'h06,
                         c_OP_BGTZ = 6'h07, c_OP_ADDIU = 6'h09, c_OP_SLTI = 6'h0A,
                         c_OP_SLTIU = 6'h0B, c_OP_ANDI = 6'h0C, c_OP_ORI = 6'h0D,
                         c_OP_XORI = 6'h0E, c_OP_LUI = 6'h0F, c_OP_LW = 6'h23,
                         c_OP_SW = 6'h2B;

  logic [31:0] r_pc, r_npc;
  logic        r_active, r_halt_pend;
  logic [31:0] r_gpr [0:31];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_sh;
  logic [15:0] w_imm;
  logic [31:0] w_sext, w_zext, w_rs_val, w_rt_val, w_pc4, w_br_target;
  logic        w_commit, w_we, w_taken, w_is_lw, w_is_sw;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata, w_target;

  assign w_op     = instr_readdata[31:26];
  assign w_rs     = instr_readdata[25:21];
  assign w_rt     = instr_readdata[20:16];
  assign w_rd     = instr_readdata[15:11];
  assign w_shamt  = instr_readdata[10:6];
  assign w_funct  = instr_readdata[5:0];
  assign w_imm    = instr_readdata[15:0];
  assign w_sext   = {{16{w_imm[15]}}, w_imm};
  assign w_zext   = {16'h0000, w_imm};
  assign w_rs_val = r_gpr[w_rs];
  assign w_rt_val = r_gpr[w_rt];
  assign w_pc4    = r_pc + 32'd4;
  assign w_br_target = w_pc4 + {w_sext[29:0], 2'b00};
  // Variable shifts (SLLV/SRLV/SRAV) are the funct codes with bit 2 set.
  assign w_sh     = w_funct[2] ? w_rs_val[4:0] : w_shamt;
  assign w_commit = clk_enable & r_active;

  always_comb begin
    w_we     = 1'b0;
    w_waddr  = w_rt;
    w_wdata  = '0;
    w_taken  = 1'b0;
    w_target = w_br_target;
    w_is_lw  = 1'b0;
    w_is_sw  = 1'b0;
    case (w_op)
      c_OP_SPECIAL: begin
        w_we    = 1'b1;
        w_waddr = w_rd;
        case (w_funct)
          6'h21: w_wdata = w_rs_val + w_rt_val;
          6'h23: w_wdata = w_rs_val - w_rt_val;
          6'h24: w_wdata = w_rs_val & w_rt_val;
          6'h25: w_wdata = w_rs_val | w_rt_val;
          6'h26: w_wdata = w_rs_val ^ w_rt_val;
          6'h27: w_wdata = ~(w_rs_val | w_rt_val);
          6'h2A: w_wdata = {31'd0, $signed(w_rs_val) < $signed(w_rt_val)};
          6'h2B: w_wdata = {31'd0, w_rs_val < w_rt_val};
          6'h00, 6'h04: w_wdata = w_rt_val << w_sh;
          6'h02, 6'h06: w_wdata = w_rt_val >> w_sh;
          6'h03, 6'h07: w_wdata = $signed(w_rt_val) >>> w_sh;
          6'h08: begin
            w_we     = 1'b0;
            w_taken  = 1'b1;
            w_target = w_rs_val;
          end
          6'h09: begin
            w_wdata  = r_pc + 32'd8;
            w_taken  = 1'b1;
            w_target = w_rs_val;
          end
          default: w_we = 1'b0;
        endcase
      end
      c_OP_J: begin
        w_taken  = 1'b1;
        w_target = {w_pc4[31:28], instr_readdata[25:0], 2'b00};
      end
      c_OP_JAL: begin
        w_taken  = 1'b1;
        w_target = {w_pc4[31:28], instr_readdata[25:0], 2'b00};
        w_we     = 1'b1;
        w_waddr  = 5'd31;
        w_wdata  = r_pc + 32'd8;
      end
      c_OP_BEQ:   w_taken = (w_rs_val == w_rt_val);
      c_OP_BNE:   w_taken = (w_rs_val != w_rt_val);
      c_OP_BLEZ:  w_taken = ($signed(w_rs_val) <= 0);
      c_OP_BGTZ:  w_taken = ($signed(w_rs_val) > 0);
      c_OP_ADDIU: begin w_we = 1'b1; w_wdata = w_rs_val + w_sext; end
      c_OP_SLTI:  begin w_we = 1'b1; w_wdata = {31'd0, $signed(w_rs_val) < $signed(w_sext)}; end
      c_OP_SLTIU: begin w_we = 1'b1; w_wdata = {31'd0, w_rs_val < w_sext}; end
      c_OP_ANDI:  begin w_we = 1'b1; w_wdata = w_rs_val & w_zext; end
      c_OP_ORI:   begin w_we = 1'b1; w_wdata = w_rs_val | w_zext; end
      c_OP_XORI:  begin w_we = 1'b1; w_wdata = w_rs_val ^ w_zext; end
      c_OP_LUI:   begin w_we = 1'b1; w_wdata = {w_imm, 16'h0000}; end
      c_OP_LW:    begin w_we = 1'b1; w_wdata = data_readdata; w_is_lw = 1'b1; end
      c_OP_SW:    w_is_sw = 1'b1;
      default:    w_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_VECTOR;
      r_npc       <= RESET_VECTOR + 32'd4;
      r_active    <= 1'b1;
      r_halt_pend <= 1'b0;
      for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
    end else if (w_commit) begin
      r_npc <= w_taken ? w_target : r_npc + 32'd4;
      // The edge after a jump-to-0 retires the delay slot and stops the core.
      if (r_halt_pend) begin
        r_pc     <= '0;
        r_active <= 1'b0;
      end else begin
        r_pc <= r_npc;
        if (w_taken && (w_target == 32'd0)) r_halt_pend <= 1'b1;
      end
      if (w_we && (w_waddr != 5'd0)) r_gpr[w_waddr] <= w_wdata;
    end
  end

  assign active         = r_active;
  assign register_v0    = r_gpr[2];
  assign instr_address  = r_pc;
  assign data_address   = w_rs_val + w_sext;
  assign data_writedata = w_rt_val;
  assign data_write     = w_is_sw & w_commit & ~reset;
  assign data_read      = w_is_lw & r_active & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_mips_harvard_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mips_harvard_core: directed programs with hand-computed results.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mips_harvard_core;
  localparam logic [31:0] c_RV = 32'hBFC0_0000;

  logic        clk = 1'b0, reset = 1'b0, clk_enable = 1'b1;
  logic        active, data_write, data_read;
  logic [31:0] register_v0, instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;

  logic [31:0] rom [0:15];
  logic [31:0] ram [0:15];
  logic [31:0] r_wr_addr, r_wr_data, w_idx;
  int          n_checks = 0, n_errors = 0, wr_cnt = 0, edges;

  mips_harvard_core #(.RESET_VECTOR(c_RV)) dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .clk_enable(clk_enable), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .data_address(data_address),
    .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata)
  );

  always #5 clk = ~clk;

  assign w_idx          = (instr_address - c_RV) >> 2;
  assign instr_readdata = (w_idx < 32'd16) ? rom[w_idx[3:0]] : 32'h0;
  assign data_readdata  = ram[data_address[5:2]];

  always @(posedge clk) begin
    if (data_write) begin
      ram[data_address[5:2]] = data_writedata;
      r_wr_addr = data_address;
      r_wr_data = data_writedata;
      wr_cnt++;
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wr_cnt = 0;
  endtask

  task automatic run_until_halt(input int max_edges);
    edges = 0;
    for (int i = 0; i < max_edges; i++) begin
      @(posedge clk);
      #1 edges++;
      if (!active) break;
    end
  endtask

  localparam logic [31:0] c_JR0 = 32'h0000_0008;

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'h0;

    // Program 1: LUI/ORI then halt
    clear_rom();
    rom[0] = enc_i(6'h0F, 5'd0, 5'd2, 16'h1234);
    rom[1] = enc_i(6'h0D, 5'd2, 5'd2, 16'h5678);
    rom[2] = c_JR0;
    do_reset();
    check("rst_pc", instr_address, c_RV);
    check("rst_v0", register_v0, 32'h0);
    check("rst_active", {31'd0, active}, 32'd1);
    check("rst_dwrite", {31'd0, data_write}, 32'd0);
    check("rst_dread", {31'd0, data_read}, 32'd0);
    run_until_halt(20);
    check("p1_edges", edges, 4);
    check("p1_v0", register_v0, 32'h1234_5678);
    check("p1_active", {31'd0, active}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("p1_pc_held", instr_address, 32'h0);
    check("p1_v0_held", register_v0, 32'h1234_5678);

    // Program 2: store then load
    clear_rom();
    rom[0] = enc_i(6'h09, 5'd0, 5'd3, 16'h0055);
    rom[1] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0010);
    rom[2] = enc_i(6'h23, 5'd0, 5'd2, 16'h0010);
    rom[3] = c_JR0;
    do_reset();
    run_until_halt(20);
    check("p2_wr_cnt", wr_cnt, 1);
    check("p2_wr_addr", r_wr_addr, 32'h10);
    check("p2_wr_data", r_wr_data, 32'h55);
    check("p2_v0", register_v0, 32'h55);

    // Program 2 again, with enable dropped while SW is the current instruction
    ram[4] = 32'h0;
    do_reset();
    @(posedge clk);
    #1 clk_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_pc", instr_address, c_RV + 32'd4);
      check("hold_dwrite", {31'd0, data_write}, 32'd0);
    end
    check("hold_wr_cnt", wr_cnt, 0);
    check("hold_v0", register_v0, 32'h0);
    clk_enable = 1'b1;
    run_until_halt(20);
    check("resume_wr_cnt", wr_cnt, 1);
    check("resume_v0", register_v0, 32'h55);

    // Program 3: delay slot executes, skipped instruction does not
    clear_rom();
    rom[0] = enc_i(6'h09, 5'd0, 5'd2, 16'h0001);
    rom[1] = enc_i(6'h04, 5'd0, 5'd0, 16'h0002);
    rom[2] = enc_i(6'h09, 5'd2, 5'd2, 16'h0002);
    rom[3] = enc_i(6'h09, 5'd2, 5'd2, 16'h0004);
    rom[4] = c_JR0;
    do_reset();
    run_until_halt(20);
    check("p3_v0", register_v0, 32'h3);
    check("p3_edges", edges, 5);

    // Program 4: JAL link value
    clear_rom();
    rom[0] = {6'h03, 26'h3F0_0008};
    rom[8] = enc_r(5'd31, 5'd0, 5'd2, 5'd0, 6'h21);
    rom[9] = c_JR0;
    do_reset();
    run_until_halt(20);
    check("p4_v0", register_v0, c_RV + 32'd8);
    check("p4_active", {31'd0, active}, 32'd0);

    // Program 5: ALU step-by-step, then asynchronous reset mid-run
    clear_rom();
    rom[0] = enc_i(6'h09, 5'd0, 5'd2, 16'hFFFF);
    rom[1] = enc_r(5'd0, 5'd2, 5'd2, 5'd0, 6'h2B);
    rom[2] = enc_r(5'd2, 5'd0, 5'd2, 5'd0, 6'h2A);
    rom[3] = enc_i(6'h09, 5'd0, 5'd2, 16'hFFF0);
    rom[4] = enc_r(5'd0, 5'd2, 5'd2, 5'd2, 6'h03);
    rom[5] = enc_r(5'd0, 5'd2, 5'd2, 5'd28, 6'h02);
    rom[6] = enc_i(6'h0E, 5'd2, 5'd2, 16'hFFFF);
    rom[7] = enc_r(5'd0, 5'd2, 5'd2, 5'd0, 6'h23);
    rom[8] = enc_i(6'h0B, 5'd2, 5'd2, 16'hFFFF);
    rom[9] = enc_i(6'h09, 5'd0, 5'd2, 16'h0007);
    do_reset();
    begin
      logic [31:0] exp_v0 [0:9];
      exp_v0 = '{32'hFFFF_FFFF, 32'h1, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFC,
                 32'h0000_000F, 32'h0000_FFF0, 32'hFFFF_0010, 32'h1, 32'h7};
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1 check($sformatf("alu_step%0d", i), register_v0, exp_v0[i]);
      end
    end
    clk_enable = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_pc", instr_address, c_RV);
    check("midrst_v0", register_v0, 32'h0);
    check("midrst_active", {31'd0, active}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    clk_enable = 1'b1;
    @(posedge clk);
    #1 check("restart_v0", register_v0, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
